unidade_busca: RTL

UNIDADE_BUSCA -- requirements
Module: unidade_busca

---
 rtl/unidade_busca_pkg.sv | 23 ++
 rtl/fila_busca.sv | 69 ++++++
 rtl/unidade_busca.sv | 114 +++++++++++
 3 files changed

// File: rtl/unidade_busca_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package unidade_busca_pkg;

  localparam int LARGURA_PALAVRA   = 32;
  localparam int PROFUNDIDADE_FILA = 2;
  localparam int LARGURA_ENTRADA   = 2 * LARGURA_PALAVRA;
  localparam int LARGURA_PTR       = $clog2(PROFUNDIDADE_FILA);
  localparam int LARGURA_OCUP      = $clog2(PROFUNDIDADE_FILA + 1);

  localparam logic [LARGURA_PALAVRA-1:0] PASSO_PC = 32'd4;

  typedef enum logic [1:0] {
    BUSCA       = 2'd0,
    REDIRECIONA = 2'd1,
    PARADO      = 2'd2
  } estado_t;

  // Word-aligns a byte address by clearing its two low bits.
  function automatic logic [LARGURA_PALAVRA-1:0] alinha(input logic [LARGURA_PALAVRA-1:0] endereco);
    return {endereco[LARGURA_PALAVRA-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fila_busca.sv
// Two-entry queue of {address, instruction} pairs between fetch and decode.
module fila_busca
  import unidade_busca_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [LARGURA_ENTRADA-1:0] dado_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [LARGURA_ENTRADA-1:0] dado_o,
  output logic [LARGURA_OCUP-1:0]    ocupacao_o,
  output logic                       vazia_o
);

  logic [LARGURA_ENTRADA-1:0] mem_q [PROFUNDIDADE_FILA];
  logic [LARGURA_PTR-1:0]     ptr_esc_q, ptr_esc_d;
  logic [LARGURA_PTR-1:0]     ptr_lei_q, ptr_lei_d;
  logic [LARGURA_OCUP-1:0]    ocup_q, ocup_d;
  logic                       faz_push;
  logic                       faz_pop;
  logic                       escreve;

  always_comb begin
    faz_push  = push_i && ((ocup_q < LARGURA_OCUP'(PROFUNDIDADE_FILA)) || pop_i);
    faz_pop   = pop_i && (ocup_q != '0);
    escreve   = faz_push && !flush_i;
    ptr_esc_d = ptr_esc_q;
    ptr_lei_d = ptr_lei_q;
    ocup_d    = ocup_q;
    if (flush_i) begin
      ptr_esc_d = '0;
      ptr_lei_d = '0;
      ocup_d    = '0;
    end else begin
      if (faz_push) ptr_esc_d = ptr_esc_q + LARGURA_PTR'(1);
      if (faz_pop)  ptr_lei_d = ptr_lei_q + LARGURA_PTR'(1);
      ocup_d = ocup_q + LARGURA_OCUP'(faz_push) - LARGURA_OCUP'(faz_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_esc_q <= '0;
      ptr_lei_q <= '0;
      ocup_q    <= '0;
    end else begin
      ptr_esc_q <= ptr_esc_d;
      ptr_lei_q <= ptr_lei_d;
      ocup_q    <= ocup_d;
    end
  end

  // Storage needs no reset: an empty queue never exposes it.
  generate
    for (genvar gi = 0; gi < PROFUNDIDADE_FILA; gi++) begin : g_entrada
      always_ff @(posedge clock) begin
        if (escreve && (ptr_esc_q == LARGURA_PTR'(gi))) begin
          mem_q[gi] <= dado_i;
        end
      end
    end
  endgenerate

  assign dado_o     = mem_q[ptr_lei_q];
  assign ocupacao_o = ocup_q;
  assign vazia_o    = (ocup_q == '0);

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: issues sequential fetches to a 1-cycle memory,
// buffers returned words for decode and handles redirects and stalls.
module unidade_busca
  import unidade_busca_pkg::*;
#(
  parameter logic [LARGURA_PALAVRA-1:0] PC_INICIAL = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic [LARGURA_PALAVRA-1:0] counter,
  input  logic [LARGURA_PALAVRA-1:0] instrucao_memoria,
  input  logic                       desvio_valido,
  input  logic [LARGURA_PALAVRA-1:0] desvio_alvo,
  input  logic                       parar,
  input  logic                       decodificador_pronto,
  output logic                       instrucao_valida,
  output logic [LARGURA_PALAVRA-1:0] instrucao,
  output logic [LARGURA_PALAVRA-1:0] pc_instrucao,
  output logic                       erro_alinhamento,
  output logic [LARGURA_PALAVRA-1:0] contador_busca
);

  estado_t                    estado_q, estado_d;
  logic [LARGURA_PALAVRA-1:0] counter_q, counter_d;
  logic                       pendente_q, pendente_d;
  logic [LARGURA_PALAVRA-1:0] pc_pendente_q, pc_pendente_d;
  logic                       erro_q, erro_d;
  logic [LARGURA_PALAVRA-1:0] contador_q, contador_d;

  logic [LARGURA_ENTRADA-1:0] cabeca;
  logic [LARGURA_OCUP-1:0]    ocupacao;
  logic                       vazia;
  logic                       transferencia;
  logic                       emite;
  logic                       push;
  logic [LARGURA_OCUP:0]      carga;

  fila_busca u_fila (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (push),
    .dado_i     ({pc_pendente_q, instrucao_memoria}),
    .pop_i      (transferencia),
    .flush_i    (desvio_valido),
    .dado_o     (cabeca),
    .ocupacao_o (ocupacao),
    .vazia_o    (vazia)
  );

  assign instrucao_valida = !vazia;
  assign transferencia    = instrucao_valida && decodificador_pronto;

  // Slots committed after this edge: queued words plus the one in flight,
  // minus the word decode takes now.
  assign carga = (LARGURA_OCUP + 1)'(ocupacao) + (LARGURA_OCUP + 1)'(pendente_q)
               - (LARGURA_OCUP + 1)'(transferencia);

  always_comb begin
    estado_d      = estado_q;
    counter_d     = counter_q;
    pendente_d    = 1'b0;
    pc_pendente_d = pc_pendente_q;
    erro_d        = 1'b0;
    contador_d    = contador_q + LARGURA_PALAVRA'(transferencia);
    emite         = 1'b0;
    push          = pendente_q && !desvio_valido;

    case (estado_q)
      BUSCA:       if (parar) estado_d = PARADO;
      REDIRECIONA: estado_d = parar ? PARADO : BUSCA;
      PARADO:      if (!parar) estado_d = BUSCA;
      default:     estado_d = BUSCA;
    endcase

    // The single REDIRECIONA cycle presents the target to memory, so it
    // issues like BUSCA; this gives the target word after the third edge.
    if (desvio_valido) begin
      estado_d  = REDIRECIONA;
      counter_d = alinha(desvio_alvo);
      erro_d    = (desvio_alvo[1:0] != 2'b00);
    end else if ((estado_q == BUSCA || estado_q == REDIRECIONA) && !parar &&
                 (carga < (LARGURA_OCUP + 1)'(PROFUNDIDADE_FILA))) begin
      emite         = 1'b1;
      pendente_d    = 1'b1;
      pc_pendente_d = counter_q;
      counter_d     = counter_q + PASSO_PC;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= BUSCA;
      counter_q     <= alinha(PC_INICIAL);
      pendente_q    <= 1'b0;
      pc_pendente_q <= '0;
      erro_q        <= 1'b0;
      contador_q    <= '0;
    end else begin
      estado_q      <= estado_d;
      counter_q     <= counter_d;
      pendente_q    <= pendente_d;
      pc_pendente_q <= pc_pendente_d;
      erro_q        <= erro_d;
      contador_q    <= contador_d;
    end
  end

  assign counter          = counter_q;
  assign instrucao        = instrucao_valida ? cabeca[LARGURA_PALAVRA-1:0] : '0;
  assign pc_instrucao     = instrucao_valida ? cabeca[LARGURA_ENTRADA-1:LARGURA_PALAVRA] : '0;
  assign erro_alinhamento = erro_q;
  assign contador_busca   = contador_q;

endmodule
